period_meter: RTL
=================

PERIOD_METER -- requirements
Module: period_meter

Interface
REQ-001 Parameter N, default 20: width of all cycle counts; max measurable period 2^N-1 cycles.
REQ-002 in_clk  input  1  sole clock; all state updates on posedge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 on_off  input  1  enable; 0 forces IDLE and clears the measurement.
REQ-005 meas_in  input  1  asynchronous square wave to be measured.
REQ-006 period_count  output  N  last measured period, in in_clk cycles; directly usable as a divider freq_counter.
REQ-007 high_count  output  N  in_clk cycles meas_in was high within that period.
REQ-008 valid  output  1  one-cycle pulse when period_count/high_count update.
REQ-009 timeout  output  1  level; high while no rising edge seen for 2^N-1 cycles.

Function
REQ-010 meas_in SHALL pass through a 2-flop synchronizer, then a registered edge detector producing rise/fall pulses one cycle wide.
REQ-011 States SHALL be IDLE, ARM, MEASURE.
REQ-012 IDLE: entered whenever on_off=0; counter=0, outputs held at reset values; on_off=1 -> ARM next cycle.
REQ-013 ARM: wait for rise; counter not running; on rise -> MEASURE with counter loaded to 1.
REQ-014 MEASURE: counter increments by 1 each cycle without rise.
REQ-015 On fall in MEASURE, counter value SHALL be captured into an internal high register (non-visible).
REQ-016 On rise in MEASURE: period_count <= counter, high_count <= captured high value, valid=1 for that one cycle, timeout <= 0, counter <= 1, remain MEASURE (continuous measurement).
REQ-017 Period definition: cycles between consecutive rise pulses; input period P cycles SHALL yield period_count=P exactly in steady state.
REQ-018 Latency: outputs and valid update on the posedge following the rise-pulse cycle; rise pulse lags meas_in's transition by 3 in_clk cycles.
REQ-019 If no fall occurred since the previous rise (stuck high or sub-sampled), high_count SHALL equal period_count.
REQ-020 Saturation: counter SHALL never wrap; on reaching 2^N-1 in MEASURE: timeout <= 1, period_count <= 0, high_count <= 0, no valid, state -> ARM.
REQ-021 Rise and on_off=0 in same cycle: on_off wins, no valid.
REQ-022 on_off dropped mid-measurement: next cycle IDLE, all outputs 0, partial measurement discarded; re-enable requires a fresh ARM edge.
REQ-023 First rise after ARM SHALL NOT produce valid (no complete period yet).

Reset
REQ-024 reset_n=0 asynchronously SHALL force state IDLE, synchronizer flops 0, counter 0, period_count 0, high_count 0, valid 0, timeout 0.
REQ-025 Reset release SHALL be synchronous in effect: first state change on the posedge after reset_n rises.

Structure
REQ-026 Shared package audio_pkg SHALL hold the state enum typedef (IDLE/ARM/MEASURE) and default count width constant (20).
REQ-027 One sub-module sync_edge_detect SHALL contain the 2-flop synchronizer plus rise/fall pulse generation.
REQ-028 Arithmetic: counter width N, unsigned; saturation compare against all-ones; no division.

Verification
REQ-029 meas_in driven by divider with freq_counter=1000, 50% duty -> second and later valid pulses report period_count=1000, high_count=500.
REQ-030 Square wave high 30 / low 70 cycles -> period_count=100, high_count=30, valid every 100 cycles.
REQ-031 N=8, meas_in held low after one rise -> timeout=1 after 255 counted cycles, outputs 0, state ARM; next two rises -> valid, timeout=0.
REQ-032 on_off 1->0 at cycle 40 of a 100-cycle period -> outputs 0 next cycle, no valid; re-enable -> first valid only after two rises.
REQ-033 reset_n pulsed low mid-MEASURE between clock edges -> all outputs 0 immediately, before next posedge.
REQ-034 meas_in stuck high after a rise -> next rise never arrives -> timeout; pulse with 1-cycle low gap at period 50 -> high_count=period_count or 49 per sampling, never exceeds period_count.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared types and constants for the period meter.
package audio_pkg;

  // Default width of every cycle count in the meter.
  localparam int unsigned COUNT_W = 20;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_e;

endpackage : audio_pkg

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous input followed by a registered
// edge detector. The rise/fall pulses are one cycle wide and appear three
// clocks after the input changes.
module sync_edge_detect (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sig_i,
  output logic rise_o,
  output logic fall_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;
  logic rise_q;
  logic fall_q;

  // Synchronize, keep one cycle of history and register the edge pulses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= sig_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      rise_q  <= sync2_q & ~prev_q;
      fall_q  <= ~sync2_q & prev_q;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule : sync_edge_detect

// File: rtl/period_meter.sv
// Measures the period and high time of an asynchronous square wave in
// in_clk cycles, continuously, one result per rising edge of meas_in.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | disabled; counter and all outputs cleared
// ARM     | waiting for the first rising edge, counter stopped
// MEASURE | counting cycles since the last rising edge, reporting on each
module period_meter
  import audio_pkg::*;
#(
  parameter int unsigned N = COUNT_W
) (
  input  logic         in_clk,
  input  logic         reset_n,
  input  logic         on_off,
  input  logic         meas_in,
  output logic [N-1:0] period_count,
  output logic [N-1:0] high_count,
  output logic         valid,
  output logic         timeout
);

  localparam logic [N-1:0] CNT_ONE = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0] CNT_MAX = {N{1'b1}};

  logic         rise;
  logic         fall;
  state_e       state_q;
  logic [N-1:0] cnt_q;
  logic [N-1:0] cnt_d;
  logic [N-1:0] high_q;
  logic         fall_seen_q;
  logic [N-1:0] period_q;
  logic [N-1:0] highc_q;
  logic         valid_q;
  logic         timeout_q;

  sync_edge_detect u_sync_edge (
    .clk_i  (in_clk),
    .rst_ni (reset_n),
    .sig_i  (meas_in),
    .rise_o (rise),
    .fall_o (fall)
  );

  // Counter increment; only used below the all-ones saturation point.
  assign cnt_d = cnt_q + CNT_ONE;

  // Sequencer: counter, captured high time and registered results.
  always_ff @(posedge in_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      high_q      <= '0;
      fall_seen_q <= 1'b0;
      period_q    <= '0;
      highc_q     <= '0;
      valid_q     <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (!on_off) begin
        // Disable overrides everything, including a coincident rising edge.
        state_q     <= IDLE;
        cnt_q       <= '0;
        high_q      <= '0;
        fall_seen_q <= 1'b0;
        period_q    <= '0;
        highc_q     <= '0;
        timeout_q   <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            cnt_q   <= '0;
            state_q <= ARM;
          end
          ARM: begin
            if (rise) begin
              state_q     <= MEASURE;
              cnt_q       <= CNT_ONE;
              fall_seen_q <= 1'b0;
            end
          end
          MEASURE: begin
            if (rise) begin
              period_q    <= cnt_q;
              // Without a falling edge the wave was high for the whole period.
              highc_q     <= fall_seen_q ? high_q : cnt_q;
              valid_q     <= 1'b1;
              timeout_q   <= 1'b0;
              cnt_q       <= CNT_ONE;
              fall_seen_q <= 1'b0;
            end else if (cnt_q == CNT_MAX) begin
              timeout_q <= 1'b1;
              period_q  <= '0;
              highc_q   <= '0;
              cnt_q     <= '0;
              state_q   <= ARM;
            end else begin
              cnt_q <= cnt_d;
              if (fall) begin
                high_q      <= cnt_q;
                fall_seen_q <= 1'b1;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign period_count = period_q;
  assign high_count   = highc_q;
  assign valid        = valid_q;
  assign timeout      = timeout_q;

endmodule : period_meter
